exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt controller of the single-cycle LEGv8 core, directly downstream of maindec.
//  Consumes maindec's NotAnInstr/ERet decode flags plus the external IRQ line.
//  Drives PC redirect (vector or return), holds ELR/ESR/ERR and runs the external IRQ ack handshake.
//  Nested exceptions are masked while the handler runs.
// PARAMETERS
//  EXC_VECTOR  64'hD8    handler entry address driven on evaddr_o
//  CNT_W       8         width of saturating taken-exception counter
// PORTS
//  clk            in   1      core clock, all state updates on rising edge
//  reset          in   1      synchronous, active-high
//  pc_i           in   64     PC of instruction currently executing
//  not_an_instr_i in   1      maindec: opcode undecodable
//  eret_i         in   1      maindec: current instruction is ERET
//  ext_irq_i      in   1      external interrupt request, level
//  ext_iack_o     out  1      external interrupt acknowledge
//  exc_o          out  1      comb: take exception this cycle (suppress RegWrite/MemWrite, PC<=evaddr_o)
//  ret_o          out  1      comb: ERET honoured this cycle (PC<=elr_o)
//  evaddr_o       out  64     constant EXC_VECTOR
//  elr_o          out  64     exception link register (return PC)
//  esr_o          out  4      exception status (cause code)
//  err_o          out  1      sticky double-fault flag
//  in_handler_o   out  1      high in HANDLER or HANDLER_ACK
//  exc_count_o    out  CNT_W  taken-exception count, saturating
// BEHAVIOUR
//  Reset (sync): state RUN; elr_o=0, esr_o=0, err_o=0, ext_iack_o=0, exc_count_o=0; exc_o/ret_o follow comb rules.
//  States: RUN, HANDLER_ACK (iack high, waiting IRQ drop), HANDLER.
//  Trigger in RUN: trig = not_an_instr_i | ext_irq_i | eret_i (ERET outside handler is illegal).
//  Cause priority: not_an_instr_i / eret_i -> esr 4'b0001; else ext_irq_i -> esr 4'b0010.
//  RUN & trig: exc_o=1 same cycle (0 latency); edge: elr<=pc_i, esr<=cause, count++ (sat at all-ones).
//   cause IRQ -> HANDLER_ACK, ext_iack_o<=1; cause 0001 -> HANDLER.
//  HANDLER_ACK: ext_iack_o held 1; when ext_irq_i==0 at edge -> ext_iack_o<=0, HANDLER.
//  HANDLER / HANDLER_ACK:
//   ext_irq_i masked (no exc_o, level stays pending, retaken after return if still high).
//   eret_i -> ret_o=1 same cycle, next RUN, ext_iack_o<=0; elr/esr unchanged.
//   not_an_instr_i -> err_o<=1 (sticky until reset), exc_o=0, elr/esr unchanged, state unchanged.
//   not_an_instr_i & eret_i same cycle: eret wins, err_o not set.
//  exc_o and ret_o never both 1. exc_o only in RUN; ret_o only in handler states.
//  4-phase handshake: iack rises edge after IRQ taken, falls edge after ext_irq_i seen low.
//  Reset mid-handler: state RUN, all registers cleared, iack drops on that edge.
//  Counter saturates at 2**CNT_W-1; no wrap.
// TESTING
//  1 reset, pc_i=0x40, opcode flags 0, irq 0 -> exc_o=0, ret_o=0, elr=0, esr=0, state RUN.
//  2 pc_i=0x1C, not_an_instr_i=1 in RUN -> exc_o=1 same cycle; next: elr=0x1C, esr=0001,
//    in_handler=1, count=1; then eret_i=1 -> ret_o=1, next RUN.
//  3 ext_irq_i=1 at pc_i=0x30 -> exc_o=1; next elr=0x30, esr=0010, iack=1; hold irq 3 cycles
//    -> iack stays 1, exc_o stays 0; drop irq -> iack=0 next edge, HANDLER.
//  4 in HANDLER, not_an_instr_i=1 at pc_i=0xE0 -> exc_o=0, err_o=1, elr unchanged;
//    reset -> err_o=0.
//  5 eret_i=1 in RUN at pc_i=0x08 -> exc_o=1, ret_o=0, esr=0001, elr=0x08.
//  6 CNT_W=2: take 5 exceptions (with ERET between) -> exc_count_o=3, no wrap.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - LEGv8 exception/interrupt controller: PC redirect, ELR/ESR/ERR, IRQ ack handshake
module exc_ctrl #(
    parameter logic [63:0] EXC_VECTOR = 64'hD8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      pc_i,
    input  logic             not_an_instr_i,
    input  logic             eret_i,
    input  logic             ext_irq_i,
    output logic             ext_iack_o,
    output logic             exc_o,
    output logic             ret_o,
    output logic [63:0]      evaddr_o,
    output logic [63:0]      elr_o,
    output logic [3:0]       esr_o,
    output logic             err_o,
    output logic             in_handler_o,
    output logic [CNT_W-1:0] exc_count_o
);

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_HANDLER_ACK = 2'd1;
    localparam logic [1:0] ST_HANDLER     = 2'd2;

    localparam logic [3:0] CAUSE_SYNC = 4'b0001;
    localparam logic [3:0] CAUSE_IRQ  = 4'b0010;

    logic [1:0]       r_state;
    logic [63:0]      r_elr;
    logic [3:0]       r_esr;
    logic             r_err;
    logic             r_iack;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_run;
    logic             w_in_hnd;
    logic             w_sync;
    logic             w_trig;
    logic [3:0]       w_cause;

    assign w_in_run = (r_state == ST_RUN);
    assign w_in_hnd = (r_state == ST_HANDLER_ACK) || (r_state == ST_HANDLER);

    // ERET seen outside a handler is an illegal instruction, same cause as undecodable opcode.
    assign w_sync  = not_an_instr_i | eret_i;
    assign w_trig  = w_sync | ext_irq_i;
    assign w_cause = w_sync ? CAUSE_SYNC : CAUSE_IRQ;

    assign exc_o        = w_in_run & w_trig;
    assign ret_o        = w_in_hnd & eret_i;
    assign evaddr_o     = EXC_VECTOR;
    assign elr_o        = r_elr;
    assign esr_o        = r_esr;
    assign err_o        = r_err;
    assign ext_iack_o   = r_iack;
    assign in_handler_o = w_in_hnd;
    assign exc_count_o  = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_elr   <= '0;
            r_esr   <= '0;
            r_err   <= 1'b0;
            r_iack  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_trig) begin
                        r_elr <= pc_i;
                        r_esr <= w_cause;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_sync) begin
                            r_state <= ST_HANDLER;
                        end else begin
                            r_state <= ST_HANDLER_ACK;
                            r_iack  <= 1'b1;
                        end
                    end
                end
                ST_HANDLER_ACK: begin
                    if (eret_i) begin
                        r_state <= ST_RUN;
                        r_iack  <= 1'b0;
                    end else begin
                        if (not_an_instr_i) begin
                            r_err <= 1'b1;
                        end
                        if (!ext_irq_i) begin
                            r_state <= ST_HANDLER;
                            r_iack  <= 1'b0;
                        end
                    end
                end
                ST_HANDLER: begin
                    if (eret_i) begin
                        r_state <= ST_RUN;
                        r_iack  <= 1'b0;
                    end else if (not_an_instr_i) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_iack  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl with directed vectors
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] pc_i;
    logic        not_an_instr_i;
    logic        eret_i;
    logic        ext_irq_i;
    logic        ext_iack_o;
    logic        exc_o;
    logic        ret_o;
    logic [63:0] evaddr_o;
    logic [63:0] elr_o;
    logic [3:0]  esr_o;
    logic        err_o;
    logic        in_handler_o;
    logic [1:0]  exc_count_o;

    exc_ctrl #(.EXC_VECTOR(64'hD8), .CNT_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_i           (pc_i),
        .not_an_instr_i (not_an_instr_i),
        .eret_i         (eret_i),
        .ext_irq_i      (ext_irq_i),
        .ext_iack_o     (ext_iack_o),
        .exc_o          (exc_o),
        .ret_o          (ret_o),
        .evaddr_o       (evaddr_o),
        .elr_o          (elr_o),
        .esr_o          (esr_o),
        .err_o          (err_o),
        .in_handler_o   (in_handler_o),
        .exc_count_o    (exc_count_o)
    );

    typedef struct {
        string       nm;
        logic        exc;
        logic        ret;
        logic [63:0] elr;
        logic [3:0]  esr;
        logic        err;
        logic        iack;
        logic        inh;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   done     = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new output set every cycle; sample mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "exc_o",        64'(exc_o),        64'(e.exc));
            chk(e.nm, "ret_o",        64'(ret_o),        64'(e.ret));
            chk(e.nm, "elr_o",        elr_o,             e.elr);
            chk(e.nm, "esr_o",        64'(esr_o),        64'(e.esr));
            chk(e.nm, "err_o",        64'(err_o),        64'(e.err));
            chk(e.nm, "ext_iack_o",   64'(ext_iack_o),   64'(e.iack));
            chk(e.nm, "in_handler_o", 64'(in_handler_o), 64'(e.inh));
            chk(e.nm, "exc_count_o",  64'(exc_count_o),  64'(e.cnt));
            chk(e.nm, "evaddr_o",     evaddr_o,          64'hD8);
        end
    end

    task automatic cyc(input string nm, input logic [63:0] pc, input bit nai, input bit er, input bit irq,
                       input bit e_exc, input bit e_ret, input logic [63:0] e_elr, input logic [3:0] e_esr,
                       input bit e_err, input bit e_iack, input bit e_inh, input logic [1:0] e_cnt);
        exp_t e;
        pc_i           = pc;
        not_an_instr_i = nai;
        eret_i         = er;
        ext_irq_i      = irq;
        e.nm = nm; e.exc = e_exc; e.ret = e_ret; e.elr = e_elr; e.esr = e_esr;
        e.err = e_err; e.iack = e_iack; e.inh = e_inh; e.cnt = e_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1;
        @(posedge clk);
        #1;
        cyc(nm, 64'h40, 0, 0, 0, 0, 0, 64'h0, 4'h0, 0, 0, 0, 2'd0);
        reset = 0;
    endtask

    initial begin
        logic [63:0] prev_elr;
        logic [1:0]  c;
        reset = 1; pc_i = 64'h40; not_an_instr_i = 0; eret_i = 0; ext_irq_i = 0;

        // 1: reset state
        do_reset("reset");

        // 2: undecodable opcode, then ERET back to RUN
        cyc("t2_nai",    64'h1C, 1, 0, 0, 1, 0, 64'h0,  4'h0, 0, 0, 0, 2'd0);
        cyc("t2_hnd",    64'h20, 0, 0, 0, 0, 0, 64'h1C, 4'h1, 0, 0, 1, 2'd1);
        cyc("t2_eret",   64'h24, 0, 1, 0, 0, 1, 64'h1C, 4'h1, 0, 0, 1, 2'd1);
        cyc("t2_run",    64'h28, 0, 0, 0, 0, 0, 64'h1C, 4'h1, 0, 0, 0, 2'd1);

        // 3: external IRQ with 4-phase ack
        cyc("t3_irq",    64'h30, 0, 0, 1, 1, 0, 64'h1C, 4'h1, 0, 0, 0, 2'd1);
        cyc("t3_hold1",  64'h34, 0, 0, 1, 0, 0, 64'h30, 4'h2, 0, 1, 1, 2'd2);
        cyc("t3_hold2",  64'h38, 0, 0, 1, 0, 0, 64'h30, 4'h2, 0, 1, 1, 2'd2);
        cyc("t3_hold3",  64'h3C, 0, 0, 1, 0, 0, 64'h30, 4'h2, 0, 1, 1, 2'd2);
        cyc("t3_drop",   64'h40, 0, 0, 0, 0, 0, 64'h30, 4'h2, 0, 1, 1, 2'd2);
        cyc("t3_hnd",    64'h44, 0, 0, 0, 0, 0, 64'h30, 4'h2, 0, 0, 1, 2'd2);

        // nai and eret together in handler: eret wins, no double fault
        cyc("both_eret", 64'h48, 1, 1, 0, 0, 1, 64'h30, 4'h2, 0, 0, 1, 2'd2);
        cyc("t4_enter",  64'h4C, 1, 0, 0, 1, 0, 64'h30, 4'h2, 0, 0, 0, 2'd2);

        // 4: double fault in handler, cleared by reset
        cyc("t4_dbl",    64'hE0, 1, 0, 0, 0, 0, 64'h4C, 4'h1, 0, 0, 1, 2'd3);
        cyc("t4_err",    64'hE4, 0, 0, 1, 0, 0, 64'h4C, 4'h1, 1, 0, 1, 2'd3);
        do_reset("t4_reset");

        // 5: ERET in RUN is illegal
        cyc("t5_eret",   64'h08, 0, 1, 0, 1, 0, 64'h0,  4'h0, 0, 0, 0, 2'd0);
        cyc("t5_hnd",    64'h0C, 0, 0, 0, 0, 0, 64'h08, 4'h1, 0, 0, 1, 2'd1);
        cyc("t5_ret",    64'h10, 0, 1, 0, 0, 1, 64'h08, 4'h1, 0, 0, 1, 2'd1);
        cyc("t5_run",    64'h14, 0, 0, 0, 0, 0, 64'h08, 4'h1, 0, 0, 0, 2'd1);

        // 6: four more exceptions (five total) saturate the 2-bit counter at 3
        prev_elr = 64'h08;
        for (int k = 0; k < 4; k++) begin
            logic [63:0] p;
            p = 64'h100 + 64'(k * 8);
            c = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            cyc("t6_exc", p, 1, 0, 0, 1, 0, prev_elr, 4'h1, 0, 0, 0, c);
            c = (k + 2 > 3) ? 2'd3 : 2'(k + 2);
            cyc("t6_ret", p + 64'h4, 0, 1, 0, 0, 1, p, 4'h1, 0, 0, 1, c);
            prev_elr = p;
        end
        cyc("t6_sat",    64'h200, 0, 0, 0, 0, 0, prev_elr, 4'h1, 0, 0, 0, 2'd3);

        @(negedge clk);
        #1;
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
